// File: rtl/stack_sequencer.sv
// Stack push/pop sequencer: one stack memory transfer per set bit of a 16-bit register mask.
// Build option STACK_SEQ_POP_SKIP_SP_EN: a pop of bit 4 (SP) reads memory but drops the write-back.
module stack_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pop,
    input  logic [15:0] mask,
    input  logic [15:0] sp_in,
    input  logic [15:0] reg_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [3:0]  reg_sel,
    output logic        reg_wr,
    output logic [15:0] reg_wdata,
    output logic [15:0] sp_out,
    output logic        sp_wr,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pend_q, pend_d;
    logic        dir_q, dir_d;
    logic [15:0] sp_q, sp_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  reg_sel_q, reg_sel_d;
    logic [15:0] sp_out_q, sp_out_d;
    logic        sp_wr_q, sp_wr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        ack_s;
    logic        skip_s;
    logic        wb_en_s;
    logic [15:0] pend_clr_s;
    logic [15:0] sp_dec_s;
    logic [15:0] sp_inc_s;
    logic [15:0] sp_after_s;

    // Push services the lowest set bit first, pop the highest set bit first.
    function automatic logic [3:0] pick_bit(input logic [15:0] bits, input logic from_top);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (from_top) begin
                idx = bits[i] ? 4'(i) : idx;
            end else begin
                idx = bits[15 - i] ? 4'(15 - i) : idx;
            end
        end
        return idx;
    endfunction

    assign ack_s      = mem_req_q & mem_ack;
    assign pend_clr_s = pend_q & ~(16'd1 << reg_sel_q);
    assign sp_dec_s   = sp_q - 16'd2;
    assign sp_inc_s   = sp_q + 16'd2;
    assign sp_after_s = dir_q ? sp_inc_s : sp_q;

`ifdef STACK_SEQ_POP_SKIP_SP_EN
    assign skip_s = (reg_sel_q == 4'd4);
`else
    assign skip_s = 1'b0;
`endif

    // Write-back strobe lives only in the acknowledged cycle, so it follows mem_ack directly.
    assign wb_en_s   = ack_s & dir_q & ~skip_s;
    assign reg_wr    = wb_en_s;
    assign reg_wdata = wb_en_s ? mem_rdata : 16'h0000;

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        dir_d       = dir_q;
        sp_d        = sp_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        reg_sel_d   = reg_sel_q;
        sp_out_d    = sp_out_q;
        sp_wr_d     = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    pend_d    = mask;
                    dir_d     = pop;
                    sp_d      = sp_in;
                    reg_sel_d = pick_bit(mask, pop);
                    busy_d    = 1'b1;
                    if (mask == 16'h0000) begin
                        state_d  = FINISH;
                        sp_wr_d  = 1'b1;
                        done_d   = 1'b1;
                        sp_out_d = sp_in;
                    end else begin
                        state_d = XFER;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            XFER: begin
                if (mem_req_q) begin
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                        pend_d    = pend_clr_s;
                        sp_d      = sp_after_s;
                        reg_sel_d = pick_bit(pend_clr_s, dir_q);
                        if (pend_clr_s == 16'h0000) begin
                            state_d  = FINISH;
                            sp_wr_d  = 1'b1;
                            done_d   = 1'b1;
                            sp_out_d = sp_after_s;
                        end else begin
                            state_d = XFER;
                        end
                    end else begin
                        mem_req_d = 1'b1;
                    end
                end else if (pend_q == 16'h0000) begin
                    state_d  = FINISH;
                    sp_wr_d  = 1'b1;
                    done_d   = 1'b1;
                    sp_out_d = sp_q;
                end else begin
                    // Issue cycle: push pre-decrements SP, pop reads at the current SP.
                    mem_req_d = 1'b1;
                    mem_we_d  = ~dir_q;
                    if (dir_q) begin
                        mem_addr_d  = sp_q;
                        mem_wdata_d = 16'h0000;
                    end else begin
                        mem_addr_d  = sp_dec_s;
                        mem_wdata_d = reg_data;
                        sp_d        = sp_dec_s;
                    end
                end
            end

            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously so a reset abandons any sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pend_q      <= 16'h0000;
            dir_q       <= 1'b0;
            sp_q        <= 16'h0000;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            reg_sel_q   <= 4'd0;
            sp_out_q    <= 16'h0000;
            sp_wr_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            dir_q       <= dir_d;
            sp_q        <= sp_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            reg_sel_q   <= reg_sel_d;
            sp_out_q    <= sp_out_d;
            sp_wr_q     <= sp_wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign reg_sel   = reg_sel_q;
    assign sp_out    = sp_out_q;
    assign sp_wr     = sp_wr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: expected transfers are queued when a sequence starts
// and popped as the DUT issues and completes each memory request.
module tb_stack_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, pop, mem_ack;
    logic [15:0] mask, sp_in, reg_data, mem_rdata;
    logic        mem_req, mem_we, reg_wr, sp_wr, busy, done;
    logic [15:0] mem_addr, mem_wdata, reg_wdata, sp_out;
    logic [3:0]  reg_sel;

    int vectors = 0;
    int miscompares = 0;

`ifdef STACK_SEQ_POP_SKIP_SP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [3:0]  sel;
        logic [15:0] rdata;
        logic        wb;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [15:0] rd_q[$];

    always #5 clk = ~clk;

    // External register file stub: value depends only on the selected index.
    function automatic logic [15:0] reg_val(input logic [3:0] i);
        return {i, 4'h0, ~i, 4'h9};
    endfunction

    assign reg_data = reg_val(reg_sel);

    stack_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .pop(pop), .mask(mask), .sp_in(sp_in),
        .reg_data(reg_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .reg_sel(reg_sel),
        .reg_wr(reg_wr), .reg_wdata(reg_wdata), .sp_out(sp_out), .sp_wr(sp_wr),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [79:0] out_vec();
        return 80'({mem_req, mem_we, reg_wr, sp_wr, busy, done,
                    mem_addr, mem_wdata, reg_wdata, sp_out, reg_sel});
    endfunction

    task automatic run_seq(input string tag, input logic p, input logic [15:0] m,
                           input logic [15:0] sp, input int dly, input bit poke,
                           input int rst_xfer);
        logic [15:0] s;
        xfer_t       x;
        xfer_t       cur;
        int          age;
        int          xidx;
        bit          fin;
        bit          gap;
        s = sp;
        exp_q.delete();
        for (int k = 0; k < 16; k++) begin
            int i;
            i = p ? 15 - k : k;
            if (m[i]) begin
                x.sel = 4'(i);
                x.we  = !p;
                if (!p) begin
                    s       = s - 16'd2;
                    x.addr  = s;
                    x.wdata = reg_val(x.sel);
                    x.rdata = 16'h0000;
                    x.wb    = 1'b0;
                end else begin
                    x.addr  = s;
                    x.wdata = 16'h0000;
                    x.rdata = (rd_q.size() > 0) ? rd_q.pop_front() : (s ^ 16'hC3A5);
                    x.wb    = !(SKIP && i == 4);
                    s       = s + 16'd2;
                end
                exp_q.push_back(x);
            end
        end

        @(negedge clk);
        start = 1'b1; pop = p; mask = m; sp_in = sp;
        @(negedge clk);
        start = 1'b0;
        age = 0; xidx = 0; fin = 1'b0; gap = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            mem_ack = 1'b0;
            if (cyc == 0) check({tag, "_busy"}, 80'(busy), 80'(1'b1));
            if (cyc == 0 && poke) begin
                start = 1'b1; mask = 16'hFFFF; pop = !p;
            end
            if (cyc == 1) start = 1'b0;
            if (gap) begin
                check({tag, "_gap"}, 80'(mem_req), 80'(1'b0));
                gap = 1'b0;
            end else if (mem_req) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_req_unexp"}, 80'(mem_req), 80'(1'b0));
                    fin = 1'b1;
                end else if (age == 0) begin
                    cur = exp_q[0];
                    check({tag, "_issue"}, 80'({mem_we, mem_addr, mem_wdata, reg_sel}),
                          80'({cur.we, cur.addr, cur.wdata, cur.sel}));
                    if (xidx == rst_xfer) begin
                        reset = 1'b1;
                        #1;
                        check({tag, "_rst_out"}, out_vec(), 80'(0));
                        @(negedge clk);
                        reset = 1'b0;
                        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
                        #1;
                        check({tag, "_late_ack_wr"}, 80'(reg_wr), 80'(1'b0));
                        for (int j = 0; j < 2; j++) begin
                            @(negedge clk);
                            mem_ack = 1'b0;
                            check({tag, "_post_rst"}, 80'({mem_req, sp_wr, busy, done}), 80'(4'h0));
                        end
                        exp_q.delete();
                        fin = 1'b1;
                    end
                end else begin
                    check({tag, "_stable"}, 80'({mem_we, mem_addr, mem_wdata}),
                          80'({cur.we, cur.addr, cur.wdata}));
                end
                if (!fin && age == dly) begin
                    mem_ack = 1'b1; mem_rdata = cur.rdata;
                    #1;
                    if (cur.wb) begin
                        check({tag, "_wb"}, 80'({reg_wr, reg_sel, reg_wdata}),
                              80'({1'b1, cur.sel, cur.rdata}));
                    end else begin
                        check({tag, "_no_wb"}, 80'(reg_wr), 80'(1'b0));
                    end
                    void'(exp_q.pop_front());
                    xidx++; age = 0; gap = 1'b1;
                end else if (!fin) begin
                    age++;
                end
            end
            if (!fin && done) begin
                check({tag, "_done"}, 80'({sp_wr, sp_out}), 80'({1'b1, s}));
                check({tag, "_left"}, 80'(exp_q.size()), 80'(0));
                fin = 1'b1;
            end
            if (!fin) @(negedge clk);
        end
        mem_ack = 1'b0;
        check({tag, "_finished"}, 80'(fin), 80'(1'b1));
        if (rst_xfer < 0) begin
            @(negedge clk);
            start = 1'b0;
            check({tag, "_idle"}, 80'({done, sp_wr, busy}), 80'(3'b000));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pop = 1'b0; mask = 16'h0000; sp_in = 16'h0000;
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_init", out_vec(), 80'(0));
        reset = 1'b0;

        run_seq("push_ff", 1'b0, 16'h00FF, 16'h0100, 0, 1'b0, -1);
        rd_q.push_back(16'h1234); rd_q.push_back(16'hF000); rd_q.push_back(16'h0202);
        run_seq("pop_2600", 1'b1, 16'h2600, 16'h00FA, 0, 1'b0, -1);
        run_seq("pop_ff", 1'b1, 16'h00FF, 16'h0200, 1, 1'b0, -1);
        run_seq("push_wrap", 1'b0, 16'h0001, 16'h0000, 3, 1'b0, -1);
        run_seq("empty", 1'b0, 16'h0000, 16'h4321, 0, 1'b1, -1);
        run_seq("pop_wrap", 1'b1, 16'hC010, 16'hFFFE, 2, 1'b0, -1);
        run_seq("push_hi", 1'b0, 16'hC000, 16'h8001, 2, 1'b1, -1);
        run_seq("rst_mid", 1'b0, 16'h000F, 16'h1000, 0, 1'b0, 1);
        run_seq("after_rst", 1'b0, 16'h0005, 16'h0010, 0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  begin sequence, sampled only in IDLE.
REQ-004 SHALL have ports: pop  in  1  0 = push sequence, 1 = pop sequence, captured with start.
REQ-005 SHALL have ports: mask  in  16  STACK_* bitmask (bit0 AW .. bit13 PC, 14 MODRM, 15 IMM), captured with start.
REQ-006 SHALL have ports: sp_in  in  16  SP value, captured with start.
REQ-007 SHALL have ports: reg_data  in  16  value of the register selected by reg_sel (combinational, external).
REQ-008 SHALL have ports: mem_req  out  1;  mem_we  out  1;  mem_addr  out  16 (SS offset);  mem_wdata  out  16;  mem_ack  in  1;  mem_rdata  in  16.
REQ-009 SHALL have ports: reg_sel  out  4  bit index being serviced;  reg_wr  out  1  pop write-back strobe;  reg_wdata  out  16.
REQ-010 SHALL have ports: sp_out  out  16;  sp_wr  out  1;  busy  out  1;  done  out  1.

Function
REQ-011 States SHALL be IDLE, XFER, FINISH.
REQ-012 IDLE + start: capture mask/pop/sp_in into internal pend/dir/sp; go XFER (or FINISH if mask == 0); busy = 1 from the next cycle.
REQ-013 Push order SHALL be lowest set bit first (AW, CW .. PSW, PS .. PC); pop order SHALL be highest set bit first.
REQ-014 reg_sel SHALL equal the index of the current pending bit selected per REQ-013, valid whenever state == XFER.
REQ-015 Push transfer: SP SHALL be decremented by 2 (mod 2^16) and mem_addr = new SP, mem_we = 1, mem_wdata = reg_data; the decrement is applied when the transfer is issued.
REQ-016 Pop transfer: mem_addr = current SP, mem_we = 0; SP SHALL be incremented by 2 (mod 2^16) on mem_ack.
REQ-017 mem_req SHALL be held high with stable mem_addr/mem_we/mem_wdata from issue until the cycle mem_ack = 1; mem_ack while mem_req = 0 SHALL be ignored.
REQ-018 On mem_ack: clear the serviced bit in pend; on pop, assert reg_wr for exactly that cycle with reg_wdata = mem_rdata and reg_sel = serviced index.
REQ-019 A new transfer SHALL be issued in the cycle after mem_ack (min 2 cycles per transfer); when pend becomes 0, go FINISH.
REQ-020 FINISH: sp_wr = 1 and done = 1 for exactly one cycle with sp_out = final SP; next state IDLE, busy = 0.
REQ-021 SP wrap-around: sp_in = 0x0000 push yields first address 0xFFFE; pop from 0xFFFE yields next address 0x0000.
REQ-022 start while busy SHALL be ignored; no queuing.
REQ-023 mask == 0: no mem_req; done/sp_wr pulse one cycle after start with sp_out = sp_in.
REQ-024 Bits 14 (MODRM) and 15 (IMM) SHALL be treated identically to register bits; the source/sink is external via reg_sel.

Reset
REQ-025 On reset assertion, state = IDLE immediately; mem_req, mem_we, reg_wr, sp_wr, busy, done = 0; mem_addr, mem_wdata, reg_wdata, sp_out = 0x0000; reg_sel = 0.
REQ-026 Reset mid-transfer SHALL abandon the sequence with no SP write-back; a late mem_ack after reset release SHALL be ignored.

Configuration
REQ-027 Macro STACK_SEQ_POP_SKIP_SP_EN: when defined, a pop of bit 4 (SP) SHALL perform the memory read and SP increment but suppress reg_wr (POPR semantics, SP discarded).
REQ-028 When undefined, bit 4 on pop SHALL assert reg_wr like any other bit.

Verification
REQ-029 Push mask 0x00FF, sp_in 0x0100, ack every req immediately -> writes to 0x00FE..0x00F0 of AW,CW,DW,BW,SP,BP,IX,IY in order; sp_out 0x00F0, single done.
REQ-030 Pop mask 0x2600, sp_in 0x00FA, rdata 0x1234/0xF000/0x0202 -> reads 0x00FA,0x00FC,0x00FE; reg_wr sel 13,10,9 with those values; sp_out 0x0100.
REQ-031 Pop mask 0x00FF with macro defined -> 8 reads, 7 reg_wr strobes, none with reg_sel = 4; sp_out = sp_in + 16; without macro 8 strobes.
REQ-032 Push mask 0x0001, sp_in 0x0000, mem_ack delayed 3 cycles -> mem_req high 4 cycles with addr 0xFFFE stable; sp_out 0xFFFE.
REQ-033 start with mask 0x0000 -> no mem_req; done and sp_wr one cycle later, sp_out = sp_in; start during busy -> no effect.
REQ-034 Assert reset during the 2nd of 4 transfers -> outputs at reset values immediately, no sp_wr, mem_ack next cycle ignored, next start runs normally.
